// File: rtl/row_dispatch_scheduler.sv
// Row dispatch scheduler: hands rows to idle line engines, grants finished lines to the streamer in row order.
// Latency: all outputs registered; a decision made on cycle t state appears on the outputs in cycle t+1.
// Backpressure: dispatch stalls while no engine is idle or enable is low; grants wait for line_req and in-order row.
//
// Ports:
//   out_stream_aclk / periph_resetn : clock and synchronous active-low reset
//   enable                          : allow new row dispatches
//   eng_start / eng_row             : one-hot start pulse and its row
//   eng_done                        : per-engine line-complete pulses
//   line_req / line_grant           : streamer request, one-cycle grant pulse
//   line_sel / line_row             : granted buffer and its row, held until the next grant
//   line_release                    : streamer finished with the granted buffer
//   frame_done / busy / err         : end-of-frame pulse, activity level, sticky protocol error
module row_dispatch_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int Y_SIZE      = 480,
  parameter int Y_WIDTH     = 9,
  parameter int SEL_WIDTH   = $clog2(NUM_ENGINES)
) (
  input  logic                   out_stream_aclk,
  input  logic                   periph_resetn,
  input  logic                   enable,
  output logic [NUM_ENGINES-1:0] eng_start,
  output logic [Y_WIDTH-1:0]     eng_row,
  input  logic [NUM_ENGINES-1:0] eng_done,
  input  logic                   line_req,
  output logic                   line_grant,
  output logic [SEL_WIDTH-1:0]   line_sel,
  output logic [Y_WIDTH-1:0]     line_row,
  input  logic                   line_release,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [1:0] {
    ENG_IDLE      = 2'd0,
    ENG_COMPUTING = 2'd1,
    ENG_READY     = 2'd2,
    ENG_STREAMING = 2'd3
  } eng_state_e;

  // next_row needs one extra bit so it can hold Y_SIZE ("frame fully dispatched")
  // even when Y_SIZE equals 2^Y_WIDTH.
  localparam logic [Y_WIDTH:0]   ROWS     = (Y_WIDTH+1)'(Y_SIZE);
  localparam logic [Y_WIDTH:0]   NEXT_INC = (Y_WIDTH+1)'(1);
  localparam logic [Y_WIDTH-1:0] LAST_ROW = Y_WIDTH'(Y_SIZE - 1);
  localparam logic [Y_WIDTH-1:0] OUT_INC  = Y_WIDTH'(1);

  eng_state_e           eng_st_q      [NUM_ENGINES];
  eng_state_e           eng_st_d      [NUM_ENGINES];
  logic [Y_WIDTH-1:0]   eng_row_reg_q [NUM_ENGINES];
  logic [Y_WIDTH-1:0]   eng_row_reg_d [NUM_ENGINES];

  logic [Y_WIDTH:0]     next_row_q, next_row_d;
  logic [Y_WIDTH-1:0]   out_row_q, out_row_d;
  logic                 streaming_q, streaming_d;

  logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
  logic [Y_WIDTH-1:0]     eng_row_q, eng_row_d;
  logic                   line_grant_q, line_grant_d;
  logic [SEL_WIDTH-1:0]   line_sel_q, line_sel_d;
  logic [Y_WIDTH-1:0]     line_row_q, line_row_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic                 disp_found;
  logic [SEL_WIDTH-1:0] disp_idx;
  logic                 grant_found;
  logic [SEL_WIDTH-1:0] grant_idx;

  always_comb begin
    eng_st_d      = eng_st_q;
    eng_row_reg_d = eng_row_reg_q;
    next_row_d    = next_row_q;
    out_row_d     = out_row_q;
    streaming_d   = streaming_q;
    eng_start_d   = '0;
    eng_row_d     = '0;
    line_grant_d  = 1'b0;
    line_sel_d    = line_sel_q;
    line_row_d    = line_row_q;
    frame_done_d  = 1'b0;
    busy_d        = 1'b0;
    err_d         = err_q;
    disp_found    = 1'b0;
    disp_idx      = '0;
    grant_found   = 1'b0;
    grant_idx     = '0;

    // Lowest-index idle engine gets the next row.
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (!disp_found && eng_st_q[i] == ENG_IDLE) begin
        disp_found = 1'b1;
        disp_idx   = SEL_WIDTH'(i);
      end
    end

    // Only the engine holding out_row may be granted; others keep their buffer and wait.
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (!grant_found && eng_st_q[i] == ENG_READY && eng_row_reg_q[i] == out_row_q) begin
        grant_found = 1'b1;
        grant_idx   = SEL_WIDTH'(i);
      end
    end

    // Completion: every asserted bit is handled; done on a non-computing engine is an error.
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (eng_done[i]) begin
        if (eng_st_q[i] == ENG_COMPUTING) begin
          eng_st_d[i] = ENG_READY;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Release frees the streamed buffer and advances the output row. A frame-ending
    // release only happens once next_row has reached Y_SIZE, so it never collides
    // with a dispatch updating next_row in the same cycle.
    if (line_release) begin
      if (streaming_q) begin
        eng_st_d[line_sel_q] = ENG_IDLE;
        streaming_d          = 1'b0;
        if (out_row_q == LAST_ROW) begin
          frame_done_d = 1'b1;
          out_row_d    = '0;
          next_row_d   = '0;
        end else begin
          out_row_d = out_row_q + OUT_INC;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (enable && next_row_q < ROWS && disp_found) begin
      eng_st_d[disp_idx]      = ENG_COMPUTING;
      eng_row_reg_d[disp_idx] = next_row_q[Y_WIDTH-1:0];
      eng_start_d[disp_idx]   = 1'b1;
      eng_row_d               = next_row_q[Y_WIDTH-1:0];
      next_row_d              = next_row_q + NEXT_INC;
    end

    // Grant needs !streaming, so it never coincides with a release.
    if (line_req && !streaming_q && grant_found) begin
      eng_st_d[grant_idx] = ENG_STREAMING;
      streaming_d         = 1'b1;
      line_grant_d        = 1'b1;
      line_sel_d          = grant_idx;
      line_row_d          = eng_row_reg_q[grant_idx];
    end

    // A frame is in progress once any row has been dispatched and until frame_done rewinds.
    busy_d = (next_row_d != '0) || (out_row_d != '0);
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (eng_st_d[i] != ENG_IDLE) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        eng_st_q[i]      <= ENG_IDLE;
        eng_row_reg_q[i] <= '0;
      end
      next_row_q   <= '0;
      out_row_q    <= '0;
      streaming_q  <= 1'b0;
      eng_start_q  <= '0;
      eng_row_q    <= '0;
      line_grant_q <= 1'b0;
      line_sel_q   <= '0;
      line_row_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      eng_st_q      <= eng_st_d;
      eng_row_reg_q <= eng_row_reg_d;
      next_row_q    <= next_row_d;
      out_row_q     <= out_row_d;
      streaming_q   <= streaming_d;
      eng_start_q   <= eng_start_d;
      eng_row_q     <= eng_row_d;
      line_grant_q  <= line_grant_d;
      line_sel_q    <= line_sel_d;
      line_row_q    <= line_row_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign eng_start  = eng_start_q;
  assign eng_row    = eng_row_q;
  assign line_grant = line_grant_q;
  assign line_sel   = line_sel_q;
  assign line_row   = line_row_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_row_dispatch_scheduler.sv
// Testbench for row_dispatch_scheduler: randomized engines/streamer, in-order grant scoreboard.
// Latency: model predicts each cycle's registered outputs one cycle ahead.
// Backpressure: line_req randomly withheld; enable toggled to stall dispatch.
module tb_row_dispatch_scheduler;

  localparam int NE = 4;
  localparam int YS = 8;
  localparam int YW = 3;
  localparam int SW = 2;

  localparam int P_IDLE   = 0;
  localparam int P_COMP   = 1;
  localparam int P_READY  = 2;
  localparam int P_STREAM = 3;

  logic          clk = 1'b0;
  logic          periph_resetn;
  logic          enable;
  logic [NE-1:0] eng_start;
  logic [YW-1:0] eng_row;
  logic [NE-1:0] eng_done;
  logic          line_req;
  logic          line_grant;
  logic [SW-1:0] line_sel;
  logic [YW-1:0] line_row;
  logic          line_release;
  logic          frame_done;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  row_dispatch_scheduler #(
    .NUM_ENGINES(NE), .Y_SIZE(YS), .Y_WIDTH(YW), .SEL_WIDTH(SW)
  ) dut (
    .out_stream_aclk(clk),
    .periph_resetn  (periph_resetn),
    .enable         (enable),
    .eng_start      (eng_start),
    .eng_row        (eng_row),
    .eng_done       (eng_done),
    .line_req       (line_req),
    .line_grant     (line_grant),
    .line_sel       (line_sel),
    .line_row       (line_row),
    .line_release   (line_release),
    .frame_done     (frame_done),
    .busy           (busy),
    .err            (err)
  );

  typedef struct {
    int sel;
    int row;
  } line_t;

  // Lines are streamed in dispatch order, so the dispatch sequence is the expected grant sequence.
  line_t gq[$];

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  // Reference model: what each engine is doing, rows handed out, streamer ownership.
  int          ph[NE];
  int          m_next   = 0;
  bit          m_stream = 1'b0;
  int          m_srow   = 0;
  logic [NE-1:0] x_start = '0;
  int          x_erow   = 0;
  bit          x_grant  = 1'b0;
  int          x_sel    = 0;
  int          x_lrow   = 0;
  bit          x_fd     = 1'b0;
  bit          x_busy   = 1'b0;
  bit          x_err    = 1'b0;
  bit          x_rst    = 1'b1;
  bit          mon_on   = 1'b0;

  // Stimulus-side engine / streamer behaviour.
  int tmr[NE];
  int hold     = 0;
  bit auto_eng = 1'b0;
  int req_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int    oph[NE];
    int    d_idx;
    int    old_next;
    bit    g;
    line_t e;
    if (!periph_resetn) begin
      for (int i = 0; i < NE; i++) ph[i] = P_IDLE;
      m_next = 0; m_stream = 1'b0; m_srow = 0;
      gq.delete();
      x_start = '0; x_erow = 0; x_grant = 1'b0; x_sel = 0; x_lrow = 0;
      x_fd = 1'b0; x_busy = 1'b0; x_err = 1'b0; x_rst = 1'b1;
      return;
    end
    x_rst    = 1'b0;
    oph      = ph;
    old_next = m_next;
    d_idx    = -1;
    if (enable && old_next < YS) begin
      for (int i = NE - 1; i >= 0; i--) if (oph[i] == P_IDLE) d_idx = i;
    end
    g = line_req && !m_stream && (gq.size() > 0) && (oph[gq[0].sel] == P_READY);
    x_start = '0; x_grant = 1'b0; x_fd = 1'b0;
    for (int i = 0; i < NE; i++) begin
      if (eng_done[i]) begin
        if (oph[i] == P_COMP) ph[i] = P_READY;
        else x_err = 1'b1;
      end
    end
    if (line_release) begin
      if (m_stream) begin
        ph[x_sel] = P_IDLE;
        m_stream  = 1'b0;
        if (m_srow == YS - 1) begin
          x_fd   = 1'b1;
          m_next = 0;
        end
      end else begin
        x_err = 1'b1;
      end
    end
    if (d_idx >= 0) begin
      ph[d_idx]      = P_COMP;
      x_start[d_idx] = 1'b1;
      x_erow         = old_next;
      e.sel = d_idx; e.row = old_next;
      gq.push_back(e);
      m_next = old_next + 1;
    end
    if (g) begin
      ph[gq[0].sel] = P_STREAM;
      m_stream = 1'b1;
      x_grant  = 1'b1;
      x_sel    = gq[0].sel;
      x_lrow   = gq[0].row;
      m_srow   = gq[0].row;
    end
    x_busy = (m_next != 0);
    for (int i = 0; i < NE; i++) if (ph[i] != P_IDLE) x_busy = 1'b1;
  endtask

  // Monitor: compares this cycle's outputs, pops the grant scoreboard, then advances the model.
  always @(negedge clk) begin : mon
    line_t e;
    if (mon_on) begin
      chk("eng_start", 32'(eng_start), 32'(x_start));
      if (x_start != '0 || x_rst) chk("eng_row", 32'(eng_row), x_erow);
      chk("line_grant", 32'(line_grant), 32'(x_grant));
      chk("line_sel", 32'(line_sel), x_sel);
      chk("line_row", 32'(line_row), x_lrow);
      chk("frame_done", 32'(frame_done), 32'(x_fd));
      chk("busy", 32'(busy), 32'(x_busy));
      chk("err", 32'(err), 32'(x_err));
      if (line_grant) begin
        if (gq.size() == 0) begin
          checks++; failures++;
          $display("FAIL grant_order: grant sel=%0d row=%0d with no line outstanding", line_sel, line_row);
        end else begin
          e = gq.pop_front();
          chk("grant_sel_order", 32'(line_sel), e.sel);
          chk("grant_row_order", 32'(line_row), e.row);
        end
      end
      if (frame_done) frames++;
      model_step();
    end
  end

  task automatic step(input logic [NE-1:0] md, input bit mr);
    logic [NE-1:0] dn;
    bit            rl;
    @(posedge clk); #1;
    dn = md; rl = mr;
    for (int i = 0; i < NE; i++) begin
      if (auto_eng && eng_start[i]) tmr[i] = $urandom_range(1, 9);
      else if (tmr[i] > 0) begin
        tmr[i]--;
        if (tmr[i] == 0) dn[i] = 1'b1;
      end
    end
    if (line_grant) hold = $urandom_range(1, 5);
    else if (hold > 0) begin
      hold--;
      if (hold == 0) rl = 1'b1;
    end
    eng_done     = dn;
    line_release = rl;
    case (req_mode)
      0:       line_req = 1'b0;
      1:       line_req = ($urandom_range(0, 3) != 0);
      default: line_req = 1'b1;
    endcase
  endtask

  initial begin
    periph_resetn = 1'b0; enable = 1'b0; eng_done = '0; line_req = 1'b0; line_release = 1'b0;
    for (int i = 0; i < NE; i++) begin tmr[i] = 0; ph[i] = P_IDLE; end
    @(posedge clk); #1;
    mon_on = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back dispatch of rows 0..3, then no further start with every engine busy.
    periph_resetn = 1'b1; enable = 1'b1;
    repeat (6) step('0, 1'b0);

    // Out-of-order completion 2,0,3,1; grants must still come out as rows 0..3.
    req_mode = 2;
    step(4'b0100, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0010, 1'b0);
    auto_eng = 1'b1;
    repeat (60) step('0, 1'b0);

    // Random traffic with enable toggling.
    req_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step('0, 1'b0);
    end

    // Drain, then protocol errors: spurious done on an idle engine and release with no grant.
    enable = 1'b0;
    repeat (300) step('0, 1'b0);
    step(4'b1000, 1'b1);
    repeat (3) step('0, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    enable = 1'b1;
    repeat (25) step('0, 1'b0);
    chk("err_still_set", 32'(err), 32'd1);

    // Mid-frame reset; afterwards dispatch restarts at row 0 on engine 0.
    @(posedge clk); #1;
    periph_resetn = 1'b0; eng_done = '0; line_release = 1'b0; hold = 0;
    for (int i = 0; i < NE; i++) tmr[i] = 0;
    @(posedge clk); #1;
    periph_resetn = 1'b1;
    repeat (40) step('0, 1'b0);

    @(posedge clk); #1;
    checks++;
    if (frames < 3) begin
      failures++;
      $display("FAIL frame_count: got %0d frame_done pulses expected at least 3", frames);
    end
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_dispatch_scheduler.md
# row_dispatch_scheduler

Row scheduler between the pixel stream front end and a bank of `NUM_ENGINES` Mandelbrot line engines, each with a private line buffer. It hands out row indices to idle engines. It tracks each engine's row through compute, ready, and streaming. It grants completed lines to the line streamer (LUT/packer path) strictly in row order, so out-of-order engine completion never reaches the video stream.

## Interface
- `NUM_ENGINES`, 4: number of line engines; 2..8.
- `Y_SIZE`, 480: rows per frame.
- `Y_WIDTH`, 9: row index width; must satisfy 2^Y_WIDTH ≥ Y_SIZE.
- `SEL_WIDTH`, $clog2(NUM_ENGINES): engine select width.

Ports:
- `out_stream_aclk`  in  1  sole clock.
- `periph_resetn`  in  1  reset, synchronous, active-low.
- `enable`  in  1  level; allows new row dispatches.
- `eng_start`  out  NUM_ENGINES  one-hot, 1-cycle start pulse to engine i.
- `eng_row`  out  Y_WIDTH  row for the pulsed engine; valid only while `eng_start` ≠ 0.
- `eng_done`  in  NUM_ENGINES  1-cycle pulse; engine i's line buffer holds its row.
- `line_req`  in  1  level; streamer idle and wants the next line.
- `line_grant`  out  1  1-cycle pulse; streamer owns buffer `line_sel`.
- `line_sel`  out  SEL_WIDTH  granted engine; held until the next grant.
- `line_row`  out  Y_WIDTH  row of the granted line; held until the next grant.
- `line_release`  in  1  1-cycle pulse; streamer finished reading the granted buffer.
- `frame_done`  out  1  1-cycle pulse after row Y_SIZE-1 is released.
- `busy`  out  1  any engine not IDLE, or rows remain in the current frame.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Per-engine state is 2 bits: IDLE → COMPUTING → READY → STREAMING → IDLE. Each engine also has a row register.
- Counters:
  - `next_row`: next row to dispatch, 0..Y_SIZE.
  - `out_row`: next row to stream, 0..Y_SIZE-1.
  - `streaming` flag.
- Dispatch happens when `enable` && `next_row` < Y_SIZE && at least one engine is IDLE.
  - Pick the lowest-index IDLE engine.
  - Pulse its `eng_start` bit, drive `eng_row`=`next_row`, store the row in that engine's row register.
  - Engine goes to COMPUTING; `next_row`++.
  - At most one dispatch per cycle.
- `eng_done[i]` with engine i COMPUTING: engine goes to READY.
- `eng_done[i]` with engine i in any other state: ignored; set `err`.
- Multiple `eng_done` bits in one cycle are all accepted.
- Grant happens when `line_req` && !`streaming` && some READY engine has row == `out_row`.
  - Pulse `line_grant`, set `line_sel`/`line_row`.
  - Engine goes to STREAMING; set `streaming`.
  - A READY engine whose row ≠ `out_row` waits, holding its buffer.
- `line_release` while `streaming`:
  - Engine `line_sel` goes to IDLE; clear `streaming`.
  - If `out_row` == Y_SIZE-1: pulse `frame_done`, set `out_row`=0 and `next_row`=0. Otherwise `out_row`++.
- `line_release` while !`streaming`: ignored; set `err`.
- Frames do not overlap. Dispatch for row 0 of the next frame is possible only after `frame_done`.
- `enable` low mid-frame: no new dispatches. In-flight rows finish and stream normally. Dispatch resumes when `enable` returns high.
- Reset (including mid-frame):
  - All engines IDLE; counters and `streaming` cleared.
  - All outputs 0: `eng_start`, `eng_row`, `line_grant`, `line_sel`, `line_row`, `frame_done`, `busy`, `err`.
  - Engines and streamer share `periph_resetn`, so no handshake survives reset.

## Timing
- All outputs are registered. Decisions use the registered state of the prior cycle.
- Dispatch latency: qualifying condition in cycle t → `eng_start` pulse in cycle t+1.
  - After reset release with `enable` high, `eng_start[0]`/row 0 fires in cycle 1.
  - `eng_start[1]`/row 1 fires in cycle 2, and so on, up to NUM_ENGINES back-to-back pulses.
- `eng_done[i]` in cycle t → engine i READY in cycle t+1 → earliest `line_grant` in cycle t+2.
- `line_release` in cycle t:
  - Engine IDLE in cycle t+1.
  - Earliest re-dispatch of that engine (`eng_start`) in cycle t+2.
  - Earliest next `line_grant` in cycle t+2.
  - If the released row was Y_SIZE-1, `frame_done` is high in cycle t+1.
- Same-cycle `eng_done[i]` and grant evaluation: the grant sees the old state, so no grant that cycle.
- Same-cycle `line_release` and `eng_done` for different engines: both take effect.
- `busy` is updated with the state; it is low in the cycle after the `frame_done` pulse when `enable` is low.

## Test plan
- Reset, NUM_ENGINES=4, `enable`=1, Y_SIZE=8 → `eng_start` = 0001, 0010, 0100, 1000 in cycles 1–4 with rows 0–3; no 5th start.
- Engines finish in order 2,0,3,1 (`eng_done` pulses), `line_req`=1 → grants are rows 0,1,2,3 with `line_sel` 0,1,2,3; engine 2 stays READY until row 1 is released.
- Release row 0 at cycle t → `eng_start[0]` with row 4 at cycle t+2, and grant of row 1 at t+2.
- Stream all 8 rows → `frame_done` pulses once, 1 cycle after the 8th release; the next `eng_start[0]`/row 0 follows; `err`=0 throughout.
- `eng_done[3]` while engine 3 IDLE, and `line_release` with no grant outstanding → `err`=1 and sticky; state unchanged.
- Assert reset mid-frame with 2 engines COMPUTING and 1 STREAMING → next cycle all outputs 0; after release, dispatch restarts at row 0 on engine 0.
